// File: rtl/gcn_agg_pkg.sv
// Shared types and helpers for the GCN neighbour-feature aggregation path.
package gcn_agg_pkg;

   typedef enum logic {S_EMPTY, S_ACCUM} agg_state_t;

   // Sign-extend the low w bits of v to 64 bits; callers take the slice they need.
   function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
      logic signed [63:0] t;
      t = $signed(v << (64 - w));
      return t >>> (64 - w);
   endfunction

endpackage

// File: rtl/beat_counter.sv
// Counts accepted beats within a group; wraps after NUM_ELEMS-1, clear wins over enable.
module beat_counter #(
   parameter int NUM_ELEMS = 7,
   parameter int LEN_WIDTH = $clog2(NUM_ELEMS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   output logic [LEN_WIDTH-1:0] count
);

   localparam logic [LEN_WIDTH-1:0] LAST_BEAT = LEN_WIDTH'(NUM_ELEMS - 1);

   logic [LEN_WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= (count_reg == LAST_BEAT) ? '0 : count_reg + LEN_WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/feature_aggregator.sv
// Sums a stream of signed feature elements into groups of up to NUM_ELEMS
// and emits one registered sum plus group length per group.
module feature_aggregator
   import gcn_agg_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ELEMS  = 7,
   parameter int LEN_WIDTH  = $clog2(NUM_ELEMS + 1),
   parameter int ACC_WIDTH  = DATA_WIDTH + LEN_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] out_data,
   output logic [LEN_WIDTH-1:0]        out_len
);

   localparam logic [LEN_WIDTH-1:0] LAST_BEAT = LEN_WIDTH'(NUM_ELEMS - 1);

   agg_state_t           state_reg, state_next;
   logic [ACC_WIDTH-1:0] acc_reg;
   logic [LEN_WIDTH-1:0] cnt;
   logic                 out_valid_reg;
   logic [ACC_WIDTH-1:0] out_data_reg;
   logic [LEN_WIDTH-1:0] out_len_reg;

   logic                 in_fire;
   logic                 out_fire;
   logic                 close;
   logic [ACC_WIDTH-1:0] elem_ext;
   logic [ACC_WIDTH-1:0] sum;

   // The output register is a single-entry stage: accept only if it can drain.
   assign in_ready = !reset && (!out_valid_reg || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_reg && out_ready;
   assign close    = in_fire && ((cnt == LAST_BEAT) || in_last);

   assign elem_ext = ACC_WIDTH'(sext({{(64 - DATA_WIDTH){1'b0}}, in_data}, DATA_WIDTH));
   assign sum      = ((state_reg == S_ACCUM) ? acc_reg : '0) + elem_ext;

   beat_counter #(
      .NUM_ELEMS (NUM_ELEMS),
      .LEN_WIDTH (LEN_WIDTH)
   ) u_beat_counter (
      .clk    (clk),
      .reset  (reset),
      .enable (in_fire),
      .clear  (close),
      .count  (cnt)
   );

   always_comb begin
      state_next = state_reg;
      if (in_fire) begin
         state_next = close ? S_EMPTY : S_ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_EMPTY;
         acc_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (in_fire) begin
            acc_reg <= close ? '0 : sum;
         end
         // A close in the same cycle as a drain reloads the stage instead of emptying it.
         if (close) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sum;
            out_len_reg   <= cnt + LEN_WIDTH'(1);
         end else if (out_fire) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = $signed(out_data_reg);
   assign out_len   = out_len_reg;

endmodule

// File: tb/tb_feature_aggregator.sv
// Directed bench for feature_aggregator: a vector table plus hand-built
// sequences for backpressure, reset mid-group and simultaneous drain/close.
module tb_feature_aggregator;

   localparam int DW = 8;
   localparam int NE = 7;
   localparam int LW = 3;
   localparam int AW = 11;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 in_last;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [AW-1:0] out_data;
   logic [LW-1:0]        out_len;

   int errors = 0;
   int checks = 0;

   logic mon_en = 1'b0;
   int   mon_cnt = 0;
   int   mon_sum = 0;

   typedef struct {
      logic v;
      int   d;
      logic l;
      logic r;
      logic e_rdy;
      logic e_ov;
      int   e_data;
      int   e_len;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   feature_aggregator #(
      .DATA_WIDTH (DW),
      .NUM_ELEMS  (NE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_len   (out_len)
   );

   always @(posedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         mon_cnt <= mon_cnt + 1;
         mon_sum <= mon_sum + int'(out_data);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input int d, input logic l, input logic r,
                      input logic e_rdy, input logic e_ov, input int e_data, input int e_len);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.r = r;
      t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_data = e_data; t.e_len = e_len;
      vecs.push_back(t);
   endtask

   // One cycle: drive at negedge, check in_ready before the edge, outputs after it.
   task automatic step(input string tag, input logic v, input int d, input logic l, input logic r,
                       input logic e_rdy, input logic e_ov, input int e_data, input int e_len);
      @(negedge clk);
      in_valid  = v;
      in_data   = DW'(d);
      in_last   = l;
      out_ready = r;
      #1;
      chk({tag, " in_ready"}, int'(in_ready), int'(e_rdy));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, int'(out_valid), int'(e_ov));
      if (e_ov) begin
         chk({tag, " out_data"}, int'(out_data), e_data);
         chk({tag, " out_len"}, int'(out_len), e_len);
      end
      $display("%s: v=%0d d=%0d last=%0d ordy=%0d -> irdy=%0d ov=%0d data=%0d len=%0d",
               tag, v, d, l, r, in_ready, out_valid, out_data, out_len);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Full group, signed extremes, early close, ignored idle beat, in_last on beat 7.
      for (int i = 1; i <= 6; i++) add(1, i, 0, 1, 1, 0, 0, 0);
      add(1, 7, 0, 1, 1, 1, 28, 7);
      for (int i = 0; i < 6; i++) add(1, -128, 0, 1, 1, 0, 0, 0);
      add(1, -128, 0, 1, 1, 1, -896, 7);
      for (int i = 0; i < 6; i++) add(1, 127, 0, 1, 1, 0, 0, 0);
      add(1, 127, 0, 1, 1, 1, 889, 7);
      add(1, 5, 0, 1, 1, 0, 0, 0);
      add(1, 5, 0, 1, 1, 0, 0, 0);
      add(1, 5, 1, 1, 1, 1, 15, 3);
      add(1, 9, 1, 1, 1, 1, 9, 1);
      add(0, 99, 1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 1, 0, 0, 0);
      add(1, 2, 1, 1, 1, 1, 8, 7);
      add(1, 3, 1, 1, 1, 1, 3, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", int'(in_ready), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_data", int'(out_data), 0);
      chk("reset out_len", int'(out_len), 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r,
              vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_data, vecs[i].e_len);
      end

      // Backpressure: sum of seven 1s held while the consumer stalls.
      for (int i = 0; i < 6; i++) step("bp_fill", 1, 1, 0, 0, 1, 0, 0, 0);
      step("bp_close", 1, 1, 0, 0, 1, 1, 7, 7);
      for (int i = 0; i < 10; i++) step("bp_stall", 1, 50, 1, 0, 0, 1, 7, 7);
      step("bp_release", 1, 2, 0, 1, 1, 0, 0, 0);
      step("bp_next", 1, 2, 0, 1, 1, 0, 0, 0);
      step("bp_next", 1, 2, 1, 1, 1, 1, 6, 3);

      // Reset mid-group discards the partial 40.
      for (int i = 0; i < 4; i++) step("rst_fill", 1, 10, 0, 1, 1, 0, 0, 0);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rst in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst out_data", int'(out_data), 0);
      chk("rst in_ready held", int'(in_ready), 0);
      $display("reset pulse: irdy=%0d ov=%0d", in_ready, out_valid);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step("rst_after", 1, 1, 0, 1, 1, 0, 0, 0);
      step("rst_close", 1, 1, 0, 1, 1, 1, 7, 7);
      step("drain", 0, 0, 0, 1, 1, 0, 0, 0);

      // Simultaneous drain and close: no group lost or duplicated.
      mon_en = 1'b1;
      step("sim_a", 1, 4, 0, 1, 1, 0, 0, 0);
      step("sim_a", 1, 4, 0, 1, 1, 0, 0, 0);
      step("sim_a", 1, 4, 1, 1, 1, 1, 12, 3);
      step("sim_stall", 0, 0, 0, 0, 0, 1, 12, 3);
      step("sim_stall", 0, 0, 0, 0, 0, 1, 12, 3);
      step("sim_b", 1, 20, 1, 1, 1, 1, 20, 1);
      step("sim_c", 1, 3, 0, 1, 1, 0, 0, 0);
      step("sim_c", 1, -1, 1, 1, 1, 1, 2, 2);
      step("sim_drain", 0, 0, 0, 1, 1, 0, 0, 0);
      @(negedge clk);
      mon_en = 1'b0;
      chk("sim accepted count", mon_cnt, 3);
      chk("sim accepted sum", mon_sum, 34);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/feature_aggregator.md
# feature_aggregator

- Accumulates a stream of signed feature elements into groups of up to NUM_ELEMS values and emits one sum per group, with the group length.
- Sits directly downstream of the per-element producer in the GCN aggregation path and reduces neighbour features before the combine stage.
- Contains an internal beat counter that wraps after NUM_ELEMS beats.
- Valid/ready handshake on both sides.

## Interface
- DATA_WIDTH, 8, width of signed input element
- NUM_ELEMS, 7, maximum elements per group (≥2)
- LEN_WIDTH, $clog2(NUM_ELEMS+1), width of out_len
- ACC_WIDTH, DATA_WIDTH+LEN_WIDTH, width of signed sum (cannot overflow)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept element
- in_data  in  DATA_WIDTH  signed element
- in_last  in  1  element closes the group early
- out_valid  out  1  group sum valid
- out_ready  in  1  consumer accepts sum
- out_data  out  ACC_WIDTH  signed group sum
- out_len  out  LEN_WIDTH  elements in group (1..NUM_ELEMS)

## Operation
- Input handshake: in_valid && in_ready; output handshake: out_valid && out_ready.
- States:
  - S_EMPTY: no partial group.
  - S_ACCUM: partial group held in acc, beat count in cnt.
- Each input handshake:
  - Sign-extend in_data to ACC_WIDTH and add to acc (acc is treated as 0 in S_EMPTY).
  - Increment cnt.
- A handshake closes the group when cnt == NUM_ELEMS-1 or in_last == 1. On close:
  - out_data ← acc + in_data, out_len ← cnt+1, out_valid ← 1.
  - acc ← 0, cnt ← 0, state → S_EMPTY.
- Non-closing handshake: state → S_ACCUM.
- in_last on the first beat of a group gives out_len = 1.
- in_last on beat NUM_ELEMS has the same effect as the counter wrapping; it does not double-close.
- in_ready = !reset && (!out_valid || out_ready). This makes the output register a single-entry stage, and a group completion never overwrites an unaccepted sum.
- Output handshake with no new close in the same cycle: out_valid ← 0.
- Output handshake with a close in the same cycle: out_valid stays 1 and out_data/out_len take the new group.
- Output-side stall while out_valid && !out_ready:
  - out_data and out_len stay stable.
  - acc and cnt stay unchanged because in_ready = 0.
- Reset, including mid-group: state S_EMPTY, acc 0, cnt 0, out_valid 0, out_data 0, out_len 0, in_ready 0 while asserted. The partial group is discarded.
- in_data and in_last are ignored without a handshake.

## Timing
- Latency: out_valid rises the cycle after the closing input handshake.
- Throughput: with out_ready held high, one element per cycle and no bubbles between groups. A group of N elements produces a sum every N cycles.
- in_ready depends combinationally on out_valid (registered) and out_ready only. There is no path from in_valid or in_data.
- Outputs are registered; out_data, out_len and out_valid change only on posedge clk.

## Structure
- Package gcn_agg_pkg holds:
  - typedef enum logic agg_state_t {S_EMPTY, S_ACCUM}.
  - A sign-extension helper function.
- One sub-module, beat_counter:
  - Inputs: clk, reset, enable, clear. Output: count.
  - Wraps to 0 after NUM_ELEMS-1.
  - clear has priority over enable.
  - Instantiated with enable = input handshake and clear = group close.
- Top level holds the FSM, accumulator and output register.

## Test plan
All scenarios use DATA_WIDTH=8 and NUM_ELEMS=7 (ACC_WIDTH=11).
- **Full group:** release reset, out_ready=1, send 1,2,3,4,5,6,7 on consecutive cycles. Expect out_data=28 and out_len=7, with out_valid high for exactly one cycle, the cycle after the 7th handshake.
- **Signed extremes:** send seven beats of -128. Expect out_data=-896. Then send seven beats of 127. Expect 889 with no wrap.
- **Early close:** send 5,5,5 with in_last on the 3rd beat. Expect out_data=15, out_len=3. The next beat 9 with in_last gives out_data=9, out_len=1 (accumulator fresh).
- **Backpressure:** out_ready=0 when a group of seven 1s closes. Expect:
  - out_valid=1 and in_ready=0, with out_data=7 held for 10 cycles.
  - On raising out_ready, in_ready=1 and the next group accumulates correctly.
- **Reset mid-group:** after 4 beats of 10, assert reset for one cycle. Expect out_valid=0 and in_ready=0 during reset. Then seven beats of 1 yield 7, not 47.
- **Simultaneous events:** out_ready=1 in the same cycle as the closing beat of the next group. Expect out_valid to stay 1 with the new out_data on the next cycle. Check the sums to confirm no group is lost or duplicated.
